bcp_host_loader: RTL and testbench
==================================

Name: bcp_host_loader

Overview:
- Synthesizable host-side sequencer that turns host streams into the exact port protocol of the BCP core top: CLQ node load, dummy-pointer header load, unit-clause issue, result-stack drain.
- Sits between the host/DMA fabric and the BCP core top.
- Generalised over engine count, clauses per engine, literal range and field widths.
- Adds conflict abort, back-pressured result streaming and status counters.

Parameters:
NUM_ENGINE, 4, number of BCP engines
CLAUSE_PER_ENGINE, 64, CLQ nodes loaded per engine
LIT_IDX_MAX, 100, max variable index; header entries per engine = 2*LIT_IDX_MAX+1
NODE_W, 64, width of a packed node (literals plus pointers)
PTR_W, 16, dummy pointer width
LIT_W, 8, literal width
CNT_W, 16, width of the unit-clause and status counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when idle
num_uc  in  CNT_W  unit clauses to issue this run, sampled on start
host_node / host_node_valid / host_node_ready  in/in/out  NODE_W/1/1  CLQ node stream
host_hdr / host_hdr_valid / host_hdr_ready  in/in/out  PTR_W/1/1  header pointer stream
host_uc / host_uc_valid / host_uc_ready  in/in/out  LIT_W/1/1  unit-clause stream
halt  out  1  core halt
node_in / node_in_valid / change_eng  out  NODE_W/1/1  core CLQ load
dummy_ptr / dummy_ptr_valid  out  PTR_W/1/1  core header load
mem2uca / mem2uca_valid / mem2uca_done  out  LIT_W/1/1  unit-clause issue to core
stall  in  1  core idle / awaiting unit clause
conflict  in  1  core conflict
mstack_pop  out  1  pop model stack
mstack_empty  in  1  model stack empty
mstack_lit  in  LIT_W  stack top (first-word fall-through)
res_lit / res_valid / res_ready  out/out/in  LIT_W/1/1  result literal stream
busy, done, conflict_flag  out  1 each  status
uc_cnt  out  CNT_W  unit clauses issued

Behaviour:
- Reset values: all outputs 0 except halt=1. State IDLE.
- Asynchronous reset mid-run returns to IDLE and drops every valid in the same instant. Partial loads are discarded.

FSM states: IDLE -> LOAD -> ARM -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: start latches num_uc, clears counters and flags, then enters LOAD. start while busy is ignored.
- LOAD: node and header channels run concurrently and independently.
  - Node channel: host_node_ready=1 until NUM_ENGINE*CLAUSE_PER_ENGINE nodes are accepted.
    - Each accepted node is registered onto node_in with node_in_valid=1 for exactly one cycle.
    - change_eng=1 alongside nodes whose index i satisfies i!=0 and i%CLAUSE_PER_ENGINE==0.
    - No host beat means a valid gap; the core tolerates gaps.
  - Header channel: same scheme, NUM_ENGINE*(2*LIT_IDX_MAX+1) entries onto dummy_ptr/dummy_ptr_valid, 1-cycle registered latency.
  - LOAD exits when both counts are complete.
- ARM: one cycle with all load valids low. Next cycle halt=0.
- RUN:
  - stall_q is a registered copy of stall. A rising edge (stall && !stall_q) sets uc_pending.
  - While uc_pending and host_uc_valid: host_uc_ready=1 for that cycle. Next cycle mem2uca=host_uc with mem2uca_valid=mem2uca_done=1 for exactly one cycle. uc_cnt increments and uc_pending clears.
  - Never more than one unit clause per stall rising edge.
  - Exit to DRAIN when uc_cnt==num_uc, stall=1, and no issue occurred in the last 2 cycles.
  - num_uc==0 goes straight to DRAIN.
- Conflict: conflict=1 in RUN sets sticky conflict_flag and moves to DRAIN the next cycle. Remaining unit clauses are not requested.
- DRAIN: halt=1. Exit to DONE when mstack_empty=1 and the output register is empty.
- Result drain runs in RUN and DRAIN.
  - res_lit/res_valid come from a 1-entry output register.
  - mstack_pop = !mstack_empty && (!res_valid || res_ready); the popped mstack_lit loads the register.
  - Pop and consume in the same cycle sustain 1 literal/cycle.
- DONE: done=1 for one cycle, then IDLE. busy=1 in every state except IDLE.
- Counters saturate at all-ones; they never wrap.

Optional Feature:
BCP_LOADER_PERF_EN
- Defined: adds outputs load_cycles, run_cycles, stall_cycles and res_count, each CNT_W wide.
  - Each counts cycles spent in LOAD, cycles spent in RUN, RUN cycles with stall=1, and result beats, respectively.
  - Cleared on start, saturating, held after DONE.
- Undefined: these ports and counters do not exist. Base behaviour is identical.

Test Plan:
- NUM_ENGINE=2, CLAUSE_PER_ENGINE=4, continuous host nodes -> 8 node_in_valid pulses; change_eng=1 only on node 4.
- Header stream with valid toggling every other cycle, LIT_IDX_MAX=3 -> exactly 14 dummy_ptr_valid beats in order; LOAD exits only after both channels complete.
- num_uc=3; stall rises 3 times; host_uc late by 5 cycles on the 2nd -> 3 one-cycle mem2uca pulses, values in order, uc_cnt=3, done pulse.
- conflict asserted after the 1st unit clause with num_uc=5 -> conflict_flag=1, uc_cnt=1, host_uc_ready never asserted again, done pulse.
- Stack holds 6 literals, res_ready toggles 1/0 -> 6 res beats in stack order, none lost or duplicated, mstack_pop never asserted while empty.
- rst_n asserted mid-LOAD -> halt=1, all valids 0 immediately; a new start reloads from node index 0.

Source files
------------

// File: rtl/bcp_host_loader.sv
// bcp_host_loader: host-side sequencer that turns host streams into the
// BCP core port protocol (CLQ node load, header load, unit clauses, drain).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, num_uc         run request; unit-clause budget sampled on start
//   host_node/_valid/_ready  CLQ node stream from host
//   host_hdr/_valid/_ready   dummy-pointer header stream from host
//   host_uc/_valid/_ready    unit-clause stream from host
//   halt                  core halt (low only in RUN)
//   node_in/_valid, change_eng   registered CLQ load to core
//   dummy_ptr/_valid      registered header load to core
//   mem2uca/_valid/_done  one-cycle unit-clause issue to core
//   stall, conflict       core idle/awaiting clause, core conflict
//   mstack_pop/_empty/_lit  model stack (first-word fall-through)
//   res_lit/_valid/_ready   back-pressured result stream
//   busy, done, conflict_flag, uc_cnt  status
// Optional macro BCP_LOADER_PERF_EN adds load_cycles, run_cycles,
// stall_cycles and res_count (saturating, cleared on start).

module bcp_host_loader #(
  parameter int NUM_ENGINE        = 4,
  parameter int CLAUSE_PER_ENGINE = 64,
  parameter int LIT_IDX_MAX       = 100,
  parameter int NODE_W            = 64,
  parameter int PTR_W             = 16,
  parameter int LIT_W             = 8,
  parameter int CNT_W             = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_uc,
  input  logic [NODE_W-1:0] host_node,
  input  logic              host_node_valid,
  output logic              host_node_ready,
  input  logic [PTR_W-1:0]  host_hdr,
  input  logic              host_hdr_valid,
  output logic              host_hdr_ready,
  input  logic [LIT_W-1:0]  host_uc,
  input  logic              host_uc_valid,
  output logic              host_uc_ready,
  output logic              halt,
  output logic [NODE_W-1:0] node_in,
  output logic              node_in_valid,
  output logic              change_eng,
  output logic [PTR_W-1:0]  dummy_ptr,
  output logic              dummy_ptr_valid,
  output logic [LIT_W-1:0]  mem2uca,
  output logic              mem2uca_valid,
  output logic              mem2uca_done,
  input  logic              stall,
  input  logic              conflict,
  output logic              mstack_pop,
  input  logic              mstack_empty,
  input  logic [LIT_W-1:0]  mstack_lit,
  output logic [LIT_W-1:0]  res_lit,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              conflict_flag,
`ifdef BCP_LOADER_PERF_EN
  output logic [CNT_W-1:0]  load_cycles,
  output logic [CNT_W-1:0]  run_cycles,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  res_count,
`endif
  output logic [CNT_W-1:0]  uc_cnt
);

  localparam int NODE_TOT = NUM_ENGINE * CLAUSE_PER_ENGINE;
  localparam int HDR_TOT  = NUM_ENGINE * (2 * LIT_IDX_MAX + 1);
  localparam int NCW = $clog2(NODE_TOT + 1);
  localparam int HCW = $clog2(HDR_TOT + 1);
  localparam int ECW =
    (CLAUSE_PER_ENGINE > 1) ? $clog2(CLAUSE_PER_ENGINE) : 1;
  localparam logic [NCW-1:0] NODE_END = NCW'(NODE_TOT);
  localparam logic [HCW-1:0] HDR_END  = HCW'(HDR_TOT);
  localparam logic [ECW-1:0] ENG_END  = ECW'(CLAUSE_PER_ENGINE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  num_uc_q;
  logic [NCW-1:0]    node_cnt_q;
  logic [HCW-1:0]    hdr_cnt_q;
  logic [ECW-1:0]    eng_idx_q;
  logic [NODE_W-1:0] node_q;
  logic              node_vld_q;
  logic              chg_q;
  logic [PTR_W-1:0]  ptr_q;
  logic              ptr_vld_q;
  logic              halt_q;
  logic              stall_q;
  logic              uc_pend_q;
  logic              uc_old_q;
  logic [LIT_W-1:0]  uca_q;
  logic              uca_vld_q;
  logic [CNT_W-1:0]  uc_cnt_q;
  logic [CNT_W-1:0]  uc_cnt_d;
  logic [LIT_W-1:0]  res_q;
  logic              res_vld_q;
  logic              busy_q;
  logic              done_q;
  logic              cflag_q;

  logic node_hs, hdr_hs, uc_hs;
  logic stall_rise, uc_settled;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign host_node_ready =
    (state_q == S_LOAD) && (node_cnt_q != NODE_END);
  assign host_hdr_ready =
    (state_q == S_LOAD) && (hdr_cnt_q != HDR_END);
  // Unit clauses are only requested with budget left and no conflict
  // in flight, so a conflict never lets one more clause slip through.
  assign host_uc_ready =
    (state_q == S_RUN) && uc_pend_q && host_uc_valid &&
    !conflict && (uc_cnt_q != num_uc_q);

  assign node_hs = host_node_valid && host_node_ready;
  assign hdr_hs  = host_hdr_valid && host_hdr_ready;
  assign uc_hs   = host_uc_ready;
  assign uc_cnt_d = sat_inc(uc_cnt_q);

  assign stall_rise = stall && !stall_q;
  // The core needs two cycles after an issue before its stall reflects
  // the new clause; only then is a high stall a genuine "finished".
  assign uc_settled =
    (uc_cnt_q == num_uc_q) && stall && !uca_vld_q && !uc_old_q;

  assign mstack_pop =
    ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
    !mstack_empty && (!res_vld_q || res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      num_uc_q   <= '0;
      node_cnt_q <= '0;
      hdr_cnt_q  <= '0;
      eng_idx_q  <= '0;
      node_q     <= '0;
      node_vld_q <= 1'b0;
      chg_q      <= 1'b0;
      ptr_q      <= '0;
      ptr_vld_q  <= 1'b0;
      halt_q     <= 1'b1;
      stall_q    <= 1'b0;
      uc_pend_q  <= 1'b0;
      uc_old_q   <= 1'b0;
      uca_q      <= '0;
      uca_vld_q  <= 1'b0;
      uc_cnt_q   <= '0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cflag_q    <= 1'b0;
    end else begin
      node_vld_q <= 1'b0;
      chg_q      <= 1'b0;
      ptr_vld_q  <= 1'b0;
      uca_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      uc_old_q   <= uca_vld_q;
      // Cleared in ARM so a core already stalled at release still
      // counts as a fresh request for the first clause.
      stall_q <= (state_q == S_ARM) ? 1'b0 : stall;

      if (mstack_pop) begin
        res_q     <= mstack_lit;
        res_vld_q <= 1'b1;
      end else if (res_ready) begin
        res_vld_q <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            num_uc_q   <= num_uc;
            node_cnt_q <= '0;
            hdr_cnt_q  <= '0;
            eng_idx_q  <= '0;
            uc_cnt_q   <= '0;
            uc_pend_q  <= 1'b0;
            cflag_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (node_hs) begin
            node_q     <= host_node;
            node_vld_q <= 1'b1;
            chg_q      <= (node_cnt_q != '0) && (eng_idx_q == '0);
            node_cnt_q <= node_cnt_q + 1'b1;
            eng_idx_q  <=
              (eng_idx_q == ENG_END) ? '0 : eng_idx_q + 1'b1;
          end
          if (hdr_hs) begin
            ptr_q     <= host_hdr;
            ptr_vld_q <= 1'b1;
            hdr_cnt_q <= hdr_cnt_q + 1'b1;
          end
          if (node_cnt_q == NODE_END && hdr_cnt_q == HDR_END)
            state_q <= S_ARM;
        end
        S_ARM: begin
          halt_q  <= 1'b0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (stall_rise)
            uc_pend_q <= 1'b1;
          else if (uc_hs)
            uc_pend_q <= 1'b0;
          if (uc_hs) begin
            uca_q     <= host_uc;
            uca_vld_q <= 1'b1;
            uc_cnt_q  <= uc_cnt_d;
          end
          if (conflict) begin
            cflag_q <= 1'b1;
            halt_q  <= 1'b1;
            state_q <= S_DRAIN;
          end else if (num_uc_q == '0 || uc_settled) begin
            halt_q  <= 1'b1;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mstack_empty && !res_vld_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef BCP_LOADER_PERF_EN
  logic [CNT_W-1:0] load_q, run_q, stl_q, resc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= '0;
      run_q  <= '0;
      stl_q  <= '0;
      resc_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      load_q <= '0;
      run_q  <= '0;
      stl_q  <= '0;
      resc_q <= '0;
    end else begin
      if (state_q == S_LOAD) load_q <= sat_inc(load_q);
      if (state_q == S_RUN) run_q <= sat_inc(run_q);
      if (state_q == S_RUN && stall) stl_q <= sat_inc(stl_q);
      if (res_vld_q && res_ready) resc_q <= sat_inc(resc_q);
    end
  end

  assign load_cycles  = load_q;
  assign run_cycles   = run_q;
  assign stall_cycles = stl_q;
  assign res_count    = resc_q;
`endif

  assign halt            = halt_q;
  assign node_in         = node_q;
  assign node_in_valid   = node_vld_q;
  assign change_eng      = chg_q;
  assign dummy_ptr       = ptr_q;
  assign dummy_ptr_valid = ptr_vld_q;
  assign mem2uca         = uca_q;
  assign mem2uca_valid   = uca_vld_q;
  assign mem2uca_done    = uca_vld_q;
  assign res_lit         = res_q;
  assign res_valid       = res_vld_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign conflict_flag   = cflag_q;
  assign uc_cnt          = uc_cnt_q;

endmodule

// File: tb/tb_bcp_host_loader.sv
// tb_bcp_host_loader: scoreboard bench for bcp_host_loader.
// Expected streams are queued at stimulus time; a monitor pops them.

module tb_bcp_host_loader;
  localparam int NE = 2, CPE = 4, LIM = 3;
  localparam int NW = 64, PW = 16, LW = 8, CW = 16;
  localparam int NT = NE * CPE;
  localparam int HT = NE * (2 * LIM + 1);

  logic clk, rst_n, start;
  logic [CW-1:0] num_uc;
  logic [NW-1:0] host_node;
  logic host_node_valid, host_node_ready;
  logic [PW-1:0] host_hdr;
  logic host_hdr_valid, host_hdr_ready;
  logic [LW-1:0] host_uc;
  logic host_uc_valid, host_uc_ready;
  logic halt;
  logic [NW-1:0] node_in;
  logic node_in_valid, change_eng;
  logic [PW-1:0] dummy_ptr;
  logic dummy_ptr_valid;
  logic [LW-1:0] mem2uca;
  logic mem2uca_valid, mem2uca_done;
  logic stall, conflict;
  logic mstack_pop, mstack_empty;
  logic [LW-1:0] mstack_lit;
  logic [LW-1:0] res_lit;
  logic res_valid, res_ready;
  logic busy, done, conflict_flag;
  logic [CW-1:0] uc_cnt;
`ifdef BCP_LOADER_PERF_EN
  logic [CW-1:0] load_cycles, run_cycles;
  logic [CW-1:0] stall_cycles, res_count;
`endif

  bcp_host_loader #(
    .NUM_ENGINE(NE), .CLAUSE_PER_ENGINE(CPE),
    .LIT_IDX_MAX(LIM), .NODE_W(NW), .PTR_W(PW),
    .LIT_W(LW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_uc(num_uc),
    .host_node(host_node),
    .host_node_valid(host_node_valid),
    .host_node_ready(host_node_ready),
    .host_hdr(host_hdr),
    .host_hdr_valid(host_hdr_valid),
    .host_hdr_ready(host_hdr_ready),
    .host_uc(host_uc),
    .host_uc_valid(host_uc_valid),
    .host_uc_ready(host_uc_ready),
    .halt(halt),
    .node_in(node_in),
    .node_in_valid(node_in_valid),
    .change_eng(change_eng),
    .dummy_ptr(dummy_ptr),
    .dummy_ptr_valid(dummy_ptr_valid),
    .mem2uca(mem2uca),
    .mem2uca_valid(mem2uca_valid),
    .mem2uca_done(mem2uca_done),
    .stall(stall), .conflict(conflict),
    .mstack_pop(mstack_pop),
    .mstack_empty(mstack_empty),
    .mstack_lit(mstack_lit),
    .res_lit(res_lit), .res_valid(res_valid),
    .res_ready(res_ready),
    .busy(busy), .done(done),
    .conflict_flag(conflict_flag),
`ifdef BCP_LOADER_PERF_EN
    .load_cycles(load_cycles),
    .run_cycles(run_cycles),
    .stall_cycles(stall_cycles),
    .res_count(res_count),
`endif
    .uc_cnt(uc_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [NW-1:0] node_arr [NT];
  logic [PW-1:0] hdr_arr [HT];
  int node_idx, hdr_idx;
  bit node_en, hdr_en;
  int node_mode, hdr_mode, res_mode;

  logic [NW-1:0] exp_node_q [$];
  bit            exp_ce_q [$];
  logic [PW-1:0] exp_hdr_q [$];
  logic [LW-1:0] exp_uc_q [$];
  logic [LW-1:0] exp_res_q [$];
  logic [LW-1:0] stk [$];

  int done_cycles;
  bit prev_halt, prev_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event-missing required=event", nm);
  endtask

  function automatic bit beat(input int m);
    if (m == 0) return 1'b1;
    if (m == 1) return cyc[0];
    return 1'($urandom_range(0, 1));
  endfunction

  // Host-side driver: node/header streams, model stack, res_ready.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (node_en && node_idx < NT) begin
      host_node = node_arr[node_idx];
      host_node_valid = beat(node_mode);
    end else begin
      host_node_valid = 1'b0;
    end
    if (hdr_en && hdr_idx < HT) begin
      host_hdr = hdr_arr[hdr_idx];
      host_hdr_valid = beat(hdr_mode);
    end else begin
      host_hdr_valid = 1'b0;
    end
    mstack_empty = (stk.size() == 0);
    mstack_lit = (stk.size() != 0) ? stk[0] : '0;
    res_ready = beat(res_mode);
    #1;
    if (host_node_valid && host_node_ready) node_idx++;
    if (host_hdr_valid && host_hdr_ready) hdr_idx++;
    if (mstack_pop) begin
      if (stk.size() == 0) fail_now("pop_while_empty");
      else void'(stk.pop_front());
    end
  end

  // Monitor: pops expected responses as the DUT presents them.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (node_in_valid) begin
        if (exp_node_q.size() == 0) fail_now("node_extra");
        else begin
          chk("node_in", node_in, exp_node_q.pop_front());
          chk("change_eng", change_eng, exp_ce_q.pop_front());
        end
      end else if (change_eng) begin
        fail_now("change_eng_no_valid");
      end
      if (dummy_ptr_valid) begin
        if (exp_hdr_q.size() == 0) fail_now("hdr_extra");
        else chk("dummy_ptr", dummy_ptr, exp_hdr_q.pop_front());
      end
      if (mem2uca_valid) begin
        if (exp_uc_q.size() == 0) fail_now("uc_extra");
        else chk("mem2uca", mem2uca, exp_uc_q.pop_front());
        chk("mem2uca_done", mem2uca_done, 1);
        chk("uc_pulse_1cyc", prev_m, 0);
      end
      if (res_valid && res_ready) begin
        if (exp_res_q.size() == 0) fail_now("res_extra");
        else chk("res_lit", res_lit, exp_res_q.pop_front());
      end
      if (done) done_cycles++;
      if (prev_halt && !halt) begin
        chk("load_nodes_done", exp_node_q.size(), 0);
        chk("load_hdrs_done", exp_hdr_q.size(), 0);
      end
      prev_halt = halt;
      prev_m = mem2uca_valid;
    end
  end

  task automatic prep_run(input int nm, input int hm,
                          input int rm, input int nstk);
    logic [LW-1:0] lit;
    exp_node_q.delete();
    exp_ce_q.delete();
    exp_hdr_q.delete();
    for (int i = 0; i < NT; i++) begin
      node_arr[i] = {$urandom, $urandom};
      exp_node_q.push_back(node_arr[i]);
      exp_ce_q.push_back((i != 0) && (i % CPE == 0));
    end
    for (int i = 0; i < HT; i++) begin
      hdr_arr[i] = PW'($urandom);
      exp_hdr_q.push_back(hdr_arr[i]);
    end
    for (int i = 0; i < nstk; i++) begin
      lit = LW'($urandom_range(1, 255));
      stk.push_back(lit);
      exp_res_q.push_back(lit);
    end
    node_idx = 0;
    hdr_idx = 0;
    node_mode = nm;
    hdr_mode = hm;
    res_mode = rm;
    node_en = 1'b1;
    hdr_en = 1'b1;
    done_cycles = 0;
  endtask

  task automatic start_run(input int n);
    int t;
    @(negedge clk);
    num_uc = CW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (t = 0; t < 400 && halt; t++) @(negedge clk);
    if (halt) fail_now("halt_release_timeout");
  endtask

  task automatic issue_uc(input logic [LW-1:0] lit,
                          input int dly, input bit take);
    bit got;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    stall = 1'b1;
    repeat (dly) @(negedge clk);
    host_uc = lit;
    host_uc_valid = 1'b1;
    if (take) exp_uc_q.push_back(lit);
    got = 1'b0;
    for (int t = 0; t < 12 && !got; t++) begin
      #1;
      if (host_uc_ready) got = 1'b1;
      @(negedge clk);
    end
    host_uc_valid = 1'b0;
    chk("uc_accepted", got, take);
  endtask

  task automatic finish_run(input int exp_cnt, input bit exp_cf);
    for (int t = 0; t < 600 && done_cycles == 0; t++)
      @(negedge clk);
    if (done_cycles == 0) fail_now("done_timeout");
    repeat (3) @(negedge clk);
    chk("done_pulse_cycles", done_cycles, 1);
    chk("uc_cnt", uc_cnt, exp_cnt);
    chk("conflict_flag", conflict_flag, exp_cf);
    chk("busy_idle", busy, 0);
    chk("halt_idle", halt, 1);
    chk("node_left", exp_node_q.size(), 0);
    chk("hdr_left", exp_hdr_q.size(), 0);
    chk("uc_left", exp_uc_q.size(), 0);
    chk("res_left", exp_res_q.size(), 0);
    chk("stack_left", stk.size(), 0);
    node_en = 1'b0;
    hdr_en = 1'b0;
  endtask

  initial begin
    int n, t;
    rst_n = 1'b0;
    start = 1'b0;
    num_uc = '0;
    host_node = '0;
    host_node_valid = 1'b0;
    host_hdr = '0;
    host_hdr_valid = 1'b0;
    host_uc = '0;
    host_uc_valid = 1'b0;
    stall = 1'b0;
    conflict = 1'b0;
    mstack_empty = 1'b1;
    mstack_lit = '0;
    res_ready = 1'b0;
    node_en = 1'b0;
    hdr_en = 1'b0;
    node_idx = 0;
    hdr_idx = 0;
    node_mode = 0;
    hdr_mode = 0;
    res_mode = 0;
    done_cycles = 0;
    prev_halt = 1'b1;
    prev_m = 1'b0;

    #12;
    chk("rst_halt", halt, 1);
    chk("rst_node_valid", node_in_valid, 0);
    chk("rst_ptr_valid", dummy_ptr_valid, 0);
    chk("rst_uca_valid", mem2uca_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_uc_cnt", uc_cnt, 0);
    chk("rst_node_ready", host_node_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous nodes, toggling headers, late 2nd clause, 6-deep stack.
    prep_run(0, 1, 1, 6);
    start_run(3);
    issue_uc(8'h11, 1, 1'b1);
    issue_uc(8'h22, 5, 1'b1);
    issue_uc(8'h33, 2, 1'b1);
    finish_run(3, 1'b0);

    // Conflict after the first of five clauses.
    prep_run(2, 2, 2, 4);
    start_run(5);
    issue_uc(8'h44, 0, 1'b1);
    repeat (2) @(negedge clk);
    conflict = 1'b1;
    @(negedge clk);
    conflict = 1'b0;
    issue_uc(8'h55, 1, 1'b0);
    finish_run(1, 1'b1);

    // Reset in the middle of LOAD; the next run restarts at node 0.
    prep_run(0, 0, 0, 0);
    @(negedge clk);
    num_uc = CW'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (t = 0; t < 100 && node_idx < 3; t++) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_halt", halt, 1);
    chk("mid_rst_node_valid", node_in_valid, 0);
    chk("mid_rst_ptr_valid", dummy_ptr_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_node_ready", host_node_ready, 0);
    node_en = 1'b0;
    hdr_en = 1'b0;
    exp_node_q.delete();
    exp_ce_q.delete();
    exp_hdr_q.delete();
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    prev_halt = 1'b1;
    prep_run(1, 0, 0, 3);
    start_run(2);
    issue_uc(8'h66, 0, 1'b1);
    issue_uc(8'h77, 3, 1'b1);
    finish_run(2, 1'b0);

    // Randomised runs, including num_uc of zero.
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(0, 4);
      prep_run($urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 8));
      start_run(n);
      for (int k = 0; k < n; k++)
        issue_uc(LW'($urandom), $urandom_range(0, 6), 1'b1);
      finish_run(n, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
